// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C transaction arbiter.
//   arb_state_t      : arbiter FSM state encoding
//   DefTimeoutCycles : default busy-to-done watchdog limit (clk cycles)
//   DefStartTimeout  : default newd-to-busy limit (clk cycles)
//   clog2()          : index width helper, never returns less than 1
package i2c_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitDone,
    StRespond,
    StDrain
  } arb_state_t;

  localparam int unsigned DefTimeoutCycles = 20000;
  localparam int unsigned DefStartTimeout  = 64;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/i2c_txn_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req       : request vector, one bit per requester
//   ptr       : highest-priority index for this pick
//   grant_idx : first set bit at or after ptr, wrapping (0 when none)
//   any_valid : at least one request is set
module rr_pick
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_valid
);

  int unsigned idx;

  always_comb begin
    grant_idx = '0;
    any_valid = 1'b0;
    idx       = 0;
    // Walk from ptr upward; the first hit wins.
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!any_valid && req[ID_W'(idx)]) begin
        any_valid = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one single-byte I2C master among NUM_REQ requesters.
//   req_*      : per-requester request (valid/op/addr/wdata) and one-cycle accept pulse
//   rsp_*      : one-cycle completion pulse to the owner with read data / error / timeout
//   m_*        : command and status interface of the shared I2C master
//   arb_busy   : arbiter not idle
//   active_id  : index of the current (or most recent) owner
// All outputs are registered. Reset is synchronous, active-high.
module i2c_txn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
  parameter int unsigned START_TIMEOUT  = DefStartTimeout,
  localparam int unsigned ID_W          = clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_op,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  output logic                 m_newd,
  output logic                 m_op,
  output logic [6:0]           m_addr,
  output logic [7:0]           m_din,
  input  logic [7:0]           m_dout,
  input  logic                 m_busy,
  input  logic                 m_done,
  input  logic                 m_ack_err,
  output logic                 arb_busy,
  output logic [ID_W-1:0]      active_id
);

  localparam int unsigned MaxWait =
      (TIMEOUT_CYCLES > START_TIMEOUT) ? TIMEOUT_CYCLES : START_TIMEOUT;
  localparam int unsigned WdW = clog2(MaxWait) + 1;
  localparam logic [WdW-1:0] DoneLimit  = WdW'(TIMEOUT_CYCLES - 1);
  localparam logic [WdW-1:0] StartLimit = WdW'(START_TIMEOUT - 1);

  arb_state_t           state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      active_id_q, active_id_d;
  logic [WdW-1:0]       wd_q, wd_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [7:0]           rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 rsp_timeout_q, rsp_timeout_d;
  logic                 m_newd_q, m_newd_d;
  logic                 m_op_q, m_op_d;
  logic [6:0]           m_addr_q, m_addr_d;
  logic [7:0]           m_din_q, m_din_d;

  logic [ID_W-1:0]      grant_idx;
  logic                 any_valid;
  logic [NUM_REQ-1:0]   grant_oh;
  logic [NUM_REQ-1:0]   active_oh;
  logic [ID_W-1:0]      ptr_next;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  assign grant_oh  = NUM_REQ'(1) << grant_idx;
  assign active_oh = NUM_REQ'(1) << active_id_q;
  assign ptr_next  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    active_id_d   = active_id_q;
    wd_d          = wd_q;
    req_ready_d   = '0;
    rsp_valid_d   = '0;
    rsp_rdata_d   = 8'h00;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    m_newd_d      = m_newd_q;
    m_op_d        = m_op_q;
    m_addr_d      = m_addr_q;
    m_din_d       = m_din_q;

    unique case (state_q)
      StIdle: begin
        // Never start while the master is still finishing something.
        if (!m_busy && any_valid) begin
          req_ready_d = grant_oh;
          m_op_d      = req_op[grant_idx];
          m_addr_d    = req_addr[7*grant_idx +: 7];
          m_din_d     = req_wdata[8*grant_idx +: 8];
          active_id_d = grant_idx;
          ptr_d       = ptr_next;
          wd_d        = '0;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (m_busy) begin
          m_newd_d = 1'b0;
          wd_d     = '0;
          state_d  = StWaitDone;
        end else if (wd_q == StartLimit) begin
          m_newd_d      = 1'b0;
          rsp_valid_d   = active_oh;
          rsp_timeout_d = 1'b1;
          state_d       = StRespond;
        end else begin
          m_newd_d = 1'b1;
          wd_d     = wd_q + WdW'(1);
        end
      end
      StWaitDone: begin
        wd_d = wd_q + WdW'(1);
        // Done is checked first so a completion on the expiry cycle is not a timeout.
        if (m_done) begin
          rsp_valid_d = active_oh;
          rsp_rdata_d = m_op_q ? m_dout : 8'h00;
          rsp_err_d   = m_ack_err;
          state_d     = StRespond;
        end else if (wd_q == DoneLimit) begin
          rsp_valid_d   = active_oh;
          rsp_timeout_d = 1'b1;
          state_d       = StRespond;
        end
      end
      StRespond: begin
        // The response pulse is on the outputs during this state.
        state_d = StDrain;
      end
      StDrain: begin
        if (!m_busy) begin
          m_op_d   = 1'b0;
          m_addr_d = '0;
          m_din_d  = '0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      active_id_q   <= '0;
      wd_q          <= '0;
      req_ready_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_rdata_q   <= 8'h00;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      m_newd_q      <= 1'b0;
      m_op_q        <= 1'b0;
      m_addr_q      <= '0;
      m_din_q       <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      active_id_q   <= active_id_d;
      wd_q          <= wd_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      m_newd_q      <= m_newd_d;
      m_op_q        <= m_op_d;
      m_addr_q      <= m_addr_d;
      m_din_q       <= m_din_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign m_newd      = m_newd_q;
  assign m_op        = m_op_q;
  assign m_addr      = m_addr_q;
  assign m_din       = m_din_q;
  assign active_id   = active_id_q;
  assign arb_busy    = (state_q != StIdle);

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter; the I2C master is modelled by the tasks below.
module tb_i2c_txn_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned TMO   = 6000;
  localparam int unsigned START = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_op = '0;
  logic [7*N-1:0] req_addr = '0;
  logic [8*N-1:0] req_wdata = '0;
  logic [N-1:0]   req_ready, rsp_valid;
  logic [7:0]     rsp_rdata;
  logic           rsp_err, rsp_timeout;
  logic           m_newd, m_op;
  logic [6:0]     m_addr;
  logic [7:0]     m_din;
  logic [7:0]     m_dout = 8'h00;
  logic           m_busy = 1'b0, m_done = 1'b0, m_ack_err = 1'b0;
  logic           arb_busy;
  logic [1:0]     active_id;
  logic [37:0]    all_out;

  int errors = 0;
  int checks = 0;

  i2c_txn_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TMO),
    .START_TIMEOUT  (START)
  ) dut (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_op (req_op), .req_addr (req_addr), .req_wdata (req_wdata),
    .req_ready (req_ready), .rsp_valid (rsp_valid), .rsp_rdata (rsp_rdata),
    .rsp_err (rsp_err), .rsp_timeout (rsp_timeout),
    .m_newd (m_newd), .m_op (m_op), .m_addr (m_addr), .m_din (m_din), .m_dout (m_dout),
    .m_busy (m_busy), .m_done (m_done), .m_ack_err (m_ack_err),
    .arb_busy (arb_busy), .active_id (active_id)
  );

  always #5 clk = ~clk;

  assign all_out = {req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, m_newd, m_op,
                    m_addr, m_din, arb_busy, active_id};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; m_busy = 1'b0; m_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Master model: wait for newd, raise busy, pulse done after done_lat WAIT_DONE cycles.
  task automatic serve(input int done_lat, input logic [7:0] dout, input logic aerr);
    int n;
    n = 0;
    while (m_newd !== 1'b1 && n < 8) begin tick(); n++; end
    checks++;
    if (m_newd !== 1'b1) begin
      errors++; $display("FAIL serve_newd: m_newd=%b required 1", m_newd);
    end
    m_busy = 1'b1; tick();
    repeat (done_lat - 1) tick();
    m_done = 1'b1; m_dout = dout; m_ack_err = aerr; tick();
    m_done = 1'b0; m_dout = 8'h00; m_ack_err = 1'b0;
  endtask

  // Master goes idle; RESPOND -> DRAIN -> IDLE.
  task automatic release_bus();
    m_busy = 1'b0; tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h required 0", all_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_write();
    bit early;
    req_valid = 4'b0010; req_op[1] = 1'b0; req_addr[13:7] = 7'h50; req_wdata[15:8] = 8'hA5;
    tick();
    checks++;
    if (req_ready !== 4'b0010 || m_newd !== 1'b0) begin
      errors++; $display("FAIL wr_grant: ready=%b newd=%b required 0010/0", req_ready, m_newd);
    end
    req_valid = '0;
    tick();
    checks++;
    if ({m_newd, m_op, m_addr, m_din, active_id, arb_busy, req_ready}
        !== {1'b1, 1'b0, 7'h50, 8'hA5, 2'd1, 1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL wr_cmd: newd=%b op=%b addr=%h din=%h id=%0d required 1/0/50/a5/1",
               m_newd, m_op, m_addr, m_din, active_id);
    end
    m_busy = 1'b1; tick();
    checks++;
    if (m_newd !== 1'b0 || m_addr !== 7'h50) begin
      errors++; $display("FAIL wr_newd_drop: newd=%b addr=%h required 0/50", m_newd, m_addr);
    end
    early = 1'b0;
    for (int i = 0; i < 4399; i++) begin
      tick();
      if (rsp_valid !== '0 || m_din !== 8'hA5) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++; $display("FAIL wr_hold: early rsp or unstable cmd seen, required none");
    end
    m_done = 1'b1; tick(); m_done = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {4'b0010, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL wr_rsp: valid=%b err=%b tmo=%b rdata=%h required 0010/0/0/00",
               rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
    end
    m_busy = 1'b0; tick();
    checks++;
    if (rsp_valid !== '0) begin
      errors++; $display("FAIL wr_rsp_pulse: valid=%b required 0000", rsp_valid);
    end
    tick();
    checks++;
    if (m_addr !== 7'h00 || m_din !== 8'h00 || arb_busy !== 1'b0) begin
      errors++; $display("FAIL wr_drain: addr=%h din=%h busy=%b required 0", m_addr, m_din,
                         arb_busy);
    end
  endtask

  task automatic test_read();
    req_valid = 4'b0001; req_op[0] = 1'b1; req_addr[6:0] = 7'h12;
    tick();
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL rd_grant: ready=%b required 0001", req_ready);
    end
    req_valid = '0;
    serve(10, 8'h12, 1'b0);
    checks++;
    if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== {4'b0001, 8'h12, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rd_rsp: valid=%b rdata=%h err=%b tmo=%b required 0001/12/0/0",
                         rsp_valid, rsp_rdata, rsp_err, rsp_timeout);
    end
    release_bus();
  endtask

  task automatic test_round_robin();
    int n;
    logic [3:0] exp;
    rst = 1'b1; tick();
    req_valid = 4'b1111; req_op = '0;
    rst = 1'b0;
    for (int t = 0; t < 5; t++) begin
      exp = 4'b0001 << (t % 4);
      n = 0;
      tick();
      while (req_ready === '0 && n < 6) begin tick(); n++; end
      checks++;
      if (req_ready !== exp || active_id !== 2'(t % 4)) begin
        errors++; $display("FAIL rr_grant%0d: ready=%b id=%0d required %b/%0d", t, req_ready,
                           active_id, exp, t % 4);
      end
      serve(5, 8'h00, 1'b0);
      checks++;
      if (rsp_valid !== exp || req_ready !== '0) begin
        errors++; $display("FAIL rr_rsp%0d: rsp=%b ready=%b required %b/0000", t, rsp_valid,
                           req_ready, exp);
      end
      release_bus();
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_watchdog();
    bit early;
    do_reset();
    req_valid = 4'b0100; req_op[2] = 1'b1; req_addr[20:14] = 7'h33;
    tick(); req_valid = '0;
    tick();
    m_busy = 1'b1; m_dout = 8'hFF; tick();
    early = 1'b0;
    for (int i = 0; i < int'(TMO) - 1; i++) begin
      tick();
      if (rsp_valid !== '0) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++; $display("FAIL wd_early: rsp before timeout, required none");
    end
    tick();
    checks++;
    if ({rsp_valid, rsp_timeout, rsp_err, rsp_rdata} !== {4'b0100, 1'b1, 1'b0, 8'h00}) begin
      errors++; $display("FAIL wd_rsp: valid=%b tmo=%b err=%b rdata=%h required 0100/1/0/00",
                         rsp_valid, rsp_timeout, rsp_err, rsp_rdata);
    end
    m_dout = 8'h00;
    // Master stays busy: no new grant may happen.
    req_valid = 4'b0001; req_op[0] = 1'b0;
    repeat (6) tick();
    checks++;
    if (req_ready !== '0 || arb_busy !== 1'b1) begin
      errors++; $display("FAIL wd_hold: ready=%b busy=%b required 0000/1", req_ready, arb_busy);
    end
    m_busy = 1'b0; tick(); tick();
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL wd_regrant: ready=%b required 0001", req_ready);
    end
    req_valid = '0;
    serve(10, 8'h77, 1'b1);
    checks++;
    if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {4'b0001, 1'b1, 1'b0, 8'h00}) begin
      errors++; $display("FAIL ack_err: valid=%b err=%b tmo=%b rdata=%h required 0001/1/0/00",
                         rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
    end
    release_bus();
  endtask

  task automatic test_coincident();
    do_reset();
    req_valid = 4'b0010; req_op[1] = 1'b1;
    tick(); req_valid = '0;
    tick();
    m_busy = 1'b1; tick();
    repeat (int'(TMO) - 1) tick();
    m_done = 1'b1; m_dout = 8'h3C; tick();
    m_done = 1'b0; m_dout = 8'h00;
    checks++;
    if ({rsp_valid, rsp_timeout, rsp_rdata} !== {4'b0010, 1'b0, 8'h3C}) begin
      errors++; $display("FAIL coincident: valid=%b tmo=%b rdata=%h required 0010/0/3c",
                         rsp_valid, rsp_timeout, rsp_rdata);
    end
    release_bus();
  endtask

  task automatic test_start_timeout();
    do_reset();
    req_valid = 4'b1000;
    tick(); req_valid = '0;
    repeat (START) tick();
    checks++;
    if ({rsp_valid, rsp_timeout, m_newd} !== {4'b1000, 1'b1, 1'b0}) begin
      errors++; $display("FAIL start_tmo: valid=%b tmo=%b newd=%b required 1000/1/0",
                         rsp_valid, rsp_timeout, m_newd);
    end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    bit bad;
    do_reset();
    req_valid = 4'b0001; req_op[0] = 1'b1; req_addr[6:0] = 7'h2A;
    tick(); req_valid = '0;
    tick();
    m_busy = 1'b1; tick(); tick(); tick();
    rst = 1'b1; tick();
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_mid: outputs=%h required 0", all_out);
    end
    m_done = 1'b1; m_dout = 8'h55;
    rst = 1'b0; m_busy = 1'b0; tick();
    m_done = 1'b0; m_dout = 8'h00;
    bad = 1'b0;
    repeat (4) begin
      tick();
      if (rsp_valid !== '0 || arb_busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL reset_mid_rsp: response or activity after reset, required none");
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_watchdog();
    test_coincident();
    test_start_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
